// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported, variable-latency memory between fetch (IF) and data (DM).
// Optional macro MEM_ARB_RR_EN: ties in IDLE go round-robin via a last-winner flop instead of fixed DM priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic [15:0]       conflict_cnt
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic        OWN_IF  = 1'b0;
    localparam logic        OWN_DM  = 1'b1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              busy_q, busy_d;
    logic [15:0]       conflict_cnt_q, conflict_cnt_d;
    logic              grant_s;
    logic              grant_dm_s;
    logic              tie_dm_s;
    logic              conflict_s;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;
    assign tie_dm_s = (last_q == OWN_IF);
`else
    assign tie_dm_s = 1'b1;
`endif

    // Next-state, grant selection, address/data capture and contention counting
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        grant_s     = 1'b0;
        grant_dm_s  = 1'b0;
        conflict_s  = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    grant_s    = 1'b1;
                    grant_dm_s = dm_req && (!if_req || tie_dm_s);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done) begin
                    state_d = S_RESP;
                    if (owner_q == OWN_DM) begin
                        dm_done_d = 1'b1;
                        if (!mem_wr_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = dm_rdata_q;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                // The owner still holds req this cycle, so only the other side can be handed the port
                if ((owner_q == OWN_DM) ? if_req : dm_req) begin
                    grant_s    = 1'b1;
                    grant_dm_s = (owner_q == OWN_IF);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant_s) begin
            state_d  = S_ISSUE;
            mem_en_d = 1'b1;
            owner_d  = grant_dm_s ? OWN_DM : OWN_IF;
`ifdef MEM_ARB_RR_EN
            last_d   = grant_dm_s ? OWN_DM : OWN_IF;
`endif
            if (grant_dm_s) begin
                mem_wr_d    = dm_wr;
                mem_addr_d  = dm_addr;
                mem_wdata_d = dm_wdata;
            end else begin
                mem_wr_d    = 1'b0;
                mem_addr_d  = if_addr;
                mem_wdata_d = {DATA_W{1'b0}};
            end
        end else begin
            owner_d = owner_q;
        end

        busy_d = (state_d != S_IDLE);

        // In IDLE the loser of a tie waits; otherwise the non-owner waits whenever it requests
        if (state_q == S_IDLE) begin
            conflict_s = if_req && dm_req;
        end else begin
            conflict_s = (owner_q == OWN_IF) ? dm_req : if_req;
        end

        if (conflict_s && (conflict_cnt_q != CNT_MAX)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            owner_q        <= OWN_IF;
            mem_en_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= {ADDR_W{1'b0}};
            mem_wdata_q    <= {DATA_W{1'b0}};
            if_done_q      <= 1'b0;
            dm_done_q      <= 1'b0;
            if_rdata_q     <= {DATA_W{1'b0}};
            dm_rdata_q     <= {DATA_W{1'b0}};
            busy_q         <= 1'b0;
            conflict_cnt_q <= 16'd0;
`ifdef MEM_ARB_RR_EN
            last_q         <= OWN_IF;
`endif
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            mem_en_q       <= mem_en_d;
            mem_wr_q       <= mem_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            if_done_q      <= if_done_d;
            dm_done_q      <= dm_done_d;
            if_rdata_q     <= if_rdata_d;
            dm_rdata_q     <= dm_rdata_d;
            busy_q         <= busy_d;
            conflict_cnt_q <= conflict_cnt_d;
`ifdef MEM_ARB_RR_EN
            last_q         <= last_d;
`endif
        end
    end

    assign if_done      = if_done_q;
    assign dm_done      = dm_done_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign mem_en       = mem_en_q;
    assign mem_wr       = mem_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign conflict_cnt = conflict_cnt_q;
    assign if_stall     = if_req & ~if_done_q;
    assign dm_stall     = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single accesses plus hand-written
// sequences for contention, spurious/late completion, reset mid-access and counter saturation.
module tb_mem_port_arbiter;
    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_done;
    logic [15:0] dm_rdata;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        busy;
    logic [15:0] conflict_cnt;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        bit          is_dm;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
        int          dly;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t        vecs[4];
    int          n_checks;
    int          n_errors;
    int          cyc;
    int          mem_lat;
    int          mem_cnt;
    bit          if_seen;
    bit          dm_seen;
    int          en_cyc;
    logic [15:0] en_addr;
    logic        en_wr;
    logic [15:0] en_wdata;
    logic [15:0] grant_log[$];
    bit          exp_first_dm;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: memory model answers mem_done lat cycles after mem_en; requesters drop req the cycle after done
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (if_seen) if_req = 1'b0;
        if (dm_seen) dm_req = 1'b0;
        if_seen  = if_done;
        dm_seen  = dm_done;
        mem_done = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) mem_done = 1'b1;
        end
        if (mem_en) begin
            mem_cnt  = mem_lat;
            en_cyc   = cyc;
            en_addr  = mem_addr;
            en_wr    = mem_wr;
            en_wdata = mem_wdata;
            grant_log.push_back(mem_addr);
        end
        #1;
    endtask

    task automatic wait_done(input bit for_dm, input int bound, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if ((for_dm ? dm_done : if_done) == 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        check(for_dm ? "dm_done_timeout" : "if_done_timeout", 32'(dcyc >= 0), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0;
        mem_done = 1'b0; mem_cnt = 0; if_seen = 1'b0; dm_seen = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_if_done"}, 32'(if_done), 32'd0);
        check({tag, "_dm_done"}, 32'(dm_done), 32'd0);
        check({tag, "_if_rdata"}, 32'(if_rdata), 32'd0);
        check({tag, "_dm_rdata"}, 32'(dm_rdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_conflict"}, 32'(conflict_cnt), 32'd0);
    endtask

    initial begin
        int c0;
        int d1;
        int d2;
        bit any_act;

        n_checks = 0; n_errors = 0; cyc = 0; mem_lat = 1; mem_rdata = 16'h0;
        // memory latency lat => mem_done lat cycles after mem_en => done lat+1 cycles after mem_en
        vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234, 1, 2, 16'h1234};
        vecs[1] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'hA5A5, 2, 3, 16'hA5A5};
        vecs[2] = '{1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h7777, 3, 4, 16'hA5A5};
        vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 5, 6, 16'h0F0F};
`ifdef MEM_ARB_RR_EN
        exp_first_dm = 1'b0;
`else
        exp_first_dm = 1'b1;
`endif

        do_reset();
        check_zero("reset");

        for (int i = 0; i < 4; i++) begin
            mem_lat   = vecs[i].lat;
            mem_rdata = vecs[i].rdata;
            c0 = cyc;
            if (vecs[i].is_dm) begin
                dm_req = 1'b1; dm_wr = vecs[i].wr; dm_addr = vecs[i].addr; dm_wdata = vecs[i].wdata;
            end else begin
                if_req = 1'b1; if_addr = vecs[i].addr;
            end
            #1;
            check("stall_at_req", 32'(vecs[i].is_dm ? dm_stall : if_stall), 32'd1);
            wait_done(vecs[i].is_dm, 40, d1);
            check("en_cycle", 32'(en_cyc - c0), 32'd1);
            check("en_addr", 32'(en_addr), 32'(vecs[i].addr));
            check("en_wr", 32'(en_wr), 32'(vecs[i].wr));
            if (vecs[i].wr) check("en_wdata", 32'(en_wdata), 32'(vecs[i].wdata));
            check("done_delay", 32'(d1 - en_cyc), 32'(vecs[i].dly));
            check("rdata", 32'(vecs[i].is_dm ? dm_rdata : if_rdata), 32'(vecs[i].exp_rdata));
            check("stall_at_done", 32'(vecs[i].is_dm ? dm_stall : if_stall), 32'd0);
            check("solo_conflict", 32'(conflict_cnt), 32'd0);
            tick();
            check("idle_after", 32'({busy, if_done, dm_done}), 32'd0);
        end

        // Tie in IDLE right after reset: DM first, then RESP hands straight to IF
        do_reset();
        mem_lat = 1; mem_rdata = 16'h5555;
        grant_log.delete();
        c0 = cyc;
        if_req = 1'b1; if_addr = 16'h0010;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
        wait_done(1'b1, 40, d1);
        check("tie_dm_done_cycle", 32'(d1 - c0), 32'd3);
        check("tie_first_grant", 32'(grant_log[0]), 32'h0020);
        wait_done(1'b0, 40, d2);
        check("tie_handoff_en", 32'(en_cyc - d1), 32'd1);
        check("tie_second_grant", 32'(en_addr), 32'h0010);
        check("tie_if_done_cycle", 32'(d2 - d1), 32'd3);
        check("tie_conflict", 32'(conflict_cnt), 32'd4);
        check("tie_if_rdata", 32'(if_rdata), 32'h5555);
        tick();

        // DM alone, then a tie: round-robin favours IF, strict priority favours DM
        dm_req = 1'b1; dm_addr = 16'h0030;
        wait_done(1'b1, 40, d1);
        tick();
        grant_log.delete();
        if_req = 1'b1; if_addr = 16'h0011;
        dm_req = 1'b1; dm_addr = 16'h0031;
        wait_done(exp_first_dm, 40, d1);
        wait_done(!exp_first_dm, 40, d2);
        check("tie2_first_grant", 32'(grant_log[0]), exp_first_dm ? 32'h0031 : 32'h0011);
        check("tie2_second_grant", 32'(grant_log[1]), exp_first_dm ? 32'h0011 : 32'h0031);
        check("tie2_period", 32'(d2 - d1), 32'd3);
        tick();
        tick();

        // Spurious mem_done while idle
        mem_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("spurious_quiet", 32'({if_done, dm_done, mem_en, busy}), 32'd0);
        end

        // Reset while waiting on memory, then the late completion arrives
        mem_lat = 5;
        if_req = 1'b1; if_addr = 16'h0077;
        tick();
        tick();
        check("wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check_zero("midreset");
        rst = 1'b0; if_req = 1'b0;
        any_act = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            any_act = any_act | if_done | dm_done | mem_en | busy;
        end
        check("late_done_ignored", 32'(any_act), 32'd0);

        // IF blocked behind a very long DM access: counter must saturate, not wrap
        do_reset();
        mem_lat = 70010;
        if_req = 1'b1; if_addr = 16'h0100;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200;
        for (int i = 0; i < 100; i++) tick();
        check("conflict_counting", 32'(conflict_cnt), 32'd100);
        wait_done(1'b1, 70100, d1);
        check("conflict_saturated", 32'(conflict_cnt), 32'h0000FFFF);
        mem_lat = 1;
        wait_done(1'b0, 40, d2);
        check("conflict_no_wrap", 32'(conflict_cnt), 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
